muldiv_unit: RTL

//  Iterative multiply/divide unit in the execute stage, next to the ALU. It consumes
//  the EX-stage control word and operands and owns the HI/LO architectural registers.

---
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Owns the HI/LO registers. MULT/MULTU use a shift-add multiplier and
// DIV/DIVU use a restoring divider, one bit per cycle. A final FIX cycle
// applies sign correction and commits HI/LO. mthi/mtlo write HI/LO
// directly while the unit is idle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       mdopE,
    input  logic             flushE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hiwriteE,
    input  logic             lowriteE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE,
    output logic             busyE,
    output logic             doneE
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               sign_ab_q, sign_ab_d;
    logic               sign_a_q, sign_a_d;
    logic               div_zero_q, div_zero_d;

    // Operand magnitudes and signs for the op being launched.
    logic               op_signed;
    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;

    // One multiply step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH-1:0] mul_next;

    // One restoring-divide step: shift the remainder/quotient pair left and
    // try to subtract the divisor from the partial remainder.
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;

    // Sign-corrected results presented in the FIX cycle.
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // Magnitude extraction for signed ops; unsigned ops pass through raw.
    always_comb begin
        op_signed = ~mdopE[0];
        sa        = op_signed & srcaE[WIDTH-1];
        sb        = op_signed & srcbE[WIDTH-1];
        abs_a     = sa ? (~srcaE + 1'b1) : srcaE;
        abs_b     = sb ? (~srcbE + 1'b1) : srcbE;
    end

    // Datapath for a single multiply or divide iteration.
    always_comb begin
        mul_upper   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, raw_a_q} : {(WIDTH+1){1'b0}});
        mul_next    = {mul_upper, acc_q[WIDTH-1:1]};
        div_shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial   = div_shifted - {1'b0, b_q};
        div_ok      = ~div_trial[WIDTH];
        div_next    = {(div_ok ? div_trial[WIDTH-1:0] : div_shifted[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ok};
    end

    // Two's-complement sign correction of the finished magnitude result.
    always_comb begin
        prod_fixed = sign_ab_q ? (~acc_q + 1'b1) : acc_q;
        quot_fixed = sign_ab_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fixed  = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                              : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state logic: launch in IDLE, iterate in RUN, commit in FIX.
    // In the multiplier the magnitude of the multiplicand is kept in raw_a_q;
    // for divides raw_a_q holds the original dividend for the divide-by-zero
    // result.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        b_d        = b_q;
        raw_a_d    = raw_a_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        sign_ab_d  = sign_ab_q;
        sign_a_d   = sign_a_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            IDLE: begin
                if (!flushE) begin
                    if (hiwriteE) begin
                        hi_d = srcaE;
                    end
                    if (lowriteE) begin
                        lo_d = srcaE;
                    end
                    if (startE) begin
                        state_d    = RUN;
                        count_d    = '0;
                        is_div_d   = mdopE[1];
                        sign_ab_d  = sa ^ sb;
                        sign_a_d   = sa;
                        div_zero_d = (srcbE == '0);
                        b_d        = abs_b;
                        if (mdopE[1]) begin
                            raw_a_d = srcaE;
                            acc_d   = {{WIDTH{1'b0}}, abs_a};
                        end else begin
                            raw_a_d = abs_a;
                            acc_d   = {{WIDTH{1'b0}}, abs_b};
                        end
                    end
                end
            end
            RUN: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                count_d = '0;
                if (!is_div_q) begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end else if (div_zero_q) begin
                    hi_d = raw_a_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any op and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            raw_a_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            sign_ab_q  <= 1'b0;
            sign_a_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            raw_a_q    <= raw_a_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            sign_ab_q  <= sign_ab_d;
            sign_a_q   <= sign_a_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hiE   = hi_q;
    assign loE   = lo_q;
    assign busyE = (state_q != IDLE);
    assign doneE = (state_q == FIX);

endmodule
